// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg -- shared constants, FSM encoding and index helper for the
// round-robin mux arbiter.
//   NUM_REQ  : number of requesters sharing the channel (7)
//   SEL_W    : width of a requester index (3)
//   state_t  : arbiter FSM encoding (IDLE / GRANT / SWITCH)
//   rr_index : (base + offset) mod NUM_REQ, used for the circular search
package rr_arb_pkg;

    localparam int unsigned NUM_REQ = 7;
    localparam int unsigned SEL_W   = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        SWITCH = 2'd2
    } state_t;

    // base is always < NUM_REQ and offset <= NUM_REQ, so one subtraction
    // is enough to wrap the sum back into range.
    function automatic logic [SEL_W-1:0] rr_index(input logic [SEL_W-1:0] base,
                                                  input int unsigned     offset);
        int unsigned sum;
        sum = 32'(base) + offset;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return SEL_W'(sum);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick -- combinational round-robin winner search.
// Scans req circularly starting at last+1 (mod NUM_REQ) and reports the
// first set bit.
//   req  : in,  NUM_REQ bits, pending requests
//   last : in,  SEL_W bits, index of the previous grant
//   win  : out, SEL_W bits, winning index (equals last when any is low)
//   any  : out, 1 bit, high when at least one request is pending
module rr_pick
    import rr_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic [SEL_W-1:0]   win,
    output logic               any
);

    logic [SEL_W-1:0] idx;

    // Offset NUM_REQ lands back on last itself, so the previous holder is
    // considered only after every other requester.
    always_comb begin
        win = last;
        any = 1'b0;
        idx = last;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = rr_index(last, off);
            if (!any && req[idx]) begin
                win = idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter -- round-robin arbiter for seven requesters sharing a
// one-bit data channel.
//   clk       : in,  rising-edge clock
//   resetn    : in,  asynchronous active-low reset
//   req       : in,  7 bits, request per requester
//   data_in   : in,  7 bits, data bit per requester
//   gnt       : out, 7 bits, registered one-hot grant (or zero)
//   sel       : out, 3 bits, registered index of the granted requester
//   busy      : out, registered, high exactly when gnt is nonzero
//   data_out  : out, data_in[sel] while busy, else 0 (combinational)
//   dbg_state : out, current FSM state for observation
// Optional feature: define RR_ARB_TIMEOUT_EN to limit every grant to
// MAX_HOLD cycles; without it a grant lasts as long as req[sel] stays high.
//
// Handshake: a requester raises req[i] and keeps it high for as long as it
// wants the channel; gnt[i] rises one cycle later and stays high until the
// requester drops req[i] (or the hold limit expires). Every grant is followed
// by one SWITCH cycle with gnt=0 before the next winner is chosen.
module rr_mux_arbiter
    import rr_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] data_in,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic               data_out,
    output state_t             dbg_state
);

    if (MAX_HOLD == 0) begin : g_bad_max_hold
        $error("rr_mux_arbiter: MAX_HOLD must be at least 1");
    end

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q,   gnt_d;
    logic [SEL_W-1:0]   sel_q,   sel_d;
    logic [SEL_W-1:0]   last_q,  last_d;
    logic               busy_q,  busy_d;

    logic [SEL_W-1:0]   pick_idx;
    logic               pick_any;
    logic               hold_expired;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q counts GRANT edges already taken; the edge that would bring it
    // to MAX_HOLD ends the grant, giving exactly MAX_HOLD visible cycles.
    assign hold_expired = (cnt_q == CNT_W'(MAX_HOLD - 1));
`else
    assign hold_expired = 1'b0;
`endif

    rr_pick u_pick (
        .req  (req),
        .last (last_q),
        .win  (pick_idx),
        .any  (pick_any)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        busy_d  = busy_q;
`ifdef RR_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            // SWITCH arbitrates exactly like IDLE; it only exists to force
            // one gnt=0 cycle between consecutive grants.
            IDLE, SWITCH: begin
                gnt_d  = '0;
                busy_d = 1'b0;
                if (pick_any) begin
                    state_d = GRANT;
                    gnt_d   = NUM_REQ'(1) << pick_idx;
                    sel_d   = pick_idx;
                    last_d  = pick_idx;
                    busy_d  = 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
`ifdef RR_ARB_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                // Only the holder's request matters here; other req bits
                // wait for the next arbitration.
                if (!req[sel_q] || hold_expired) begin
                    state_d = SWITCH;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            // last = NUM_REQ-1 makes requester 0 first in line after reset.
            last_q  <= SEL_W'(NUM_REQ - 1);
`ifdef RR_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
`ifdef RR_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;
    assign data_out  = busy_q ? data_in[sel_q] : 1'b0;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter -- self-checking bench for rr_mux_arbiter.
// Expected grant indices are queued when requests are driven and popped by
// a monitor whenever a new grant appears; scenario tasks add inline checks.
module tb_rr_mux_arbiter;
    import rr_arb_pkg::*;

    localparam int unsigned TB_MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       resetn;
    logic [6:0] req;
    logic [6:0] data_in;
    logic [6:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       data_out;
    state_t     dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] exp_q[$];
    logic       busy_prev = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    rr_mux_arbiter #(.MAX_HOLD(TB_MAX_HOLD)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req       (req),
        .data_in   (data_in),
        .gnt       (gnt),
        .sel       (sel),
        .busy      (busy),
        .data_out  (data_out),
        .dbg_state (dbg_state)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [2:0] e;
        logic [6:0] e_gnt;
        n_checks++;
        if (busy !== (gnt != 7'd0) || !$onehot0(gnt) || sel === 3'd7) begin
            n_fail++;
            $display("FAIL invariant: gnt=%b sel=%0d busy=%b", gnt, sel, busy);
        end
        if (busy === 1'b1 && busy_prev === 1'b0) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_grant: sel=%0d gnt=%b, none expected", sel, gnt);
            end else begin
                e = exp_q.pop_front();
                e_gnt = 7'b0000001 << e;
                if (sel !== e || gnt !== e_gnt) begin
                    n_fail++;
                    $display("FAIL grant_order: got sel=%0d gnt=%b, expected sel=%0d gnt=%b",
                             sel, gnt, e, e_gnt);
                end
            end
        end
        busy_prev = busy;
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_reset();
        @(negedge clk);
        #2 resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic wait_grant(input int max_cyc, output int cyc);
        cyc = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            cyc++;
            if (busy === 1'b1) break;
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_grant: no grant after %0d cycles, busy=%b", cyc, busy);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        req     = '0;
        data_in = '0;
        resetn  = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (gnt !== 7'd0 || sel !== 3'd0 || busy !== 1'b0 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: gnt=%b sel=%0d busy=%b state=%0d, expected 0/0/0/IDLE",
                     gnt, sel, busy, dbg_state);
        end
        data_in = '1;
        #1;
        n_checks++;
        if (data_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dout: data_out=%b expected 0", data_out);
        end
        resetn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL idle_no_req: busy=%b state=%0d expected 0/IDLE", busy, dbg_state);
        end
    endtask

    task automatic test_reset_priority();
        @(negedge clk);
        req = 7'b0000001;
        exp_q.push_back(3'd0);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || sel !== 3'd0 || gnt !== 7'b0000001) begin
            n_fail++;
            $display("FAIL first_grant_latency: busy=%b sel=%0d gnt=%b expected 1/0/0000001",
                     busy, sel, gnt);
        end
        data_in = 7'b0000001;
        #1;
        n_checks++;
        if (data_out !== 1'b1) begin
            n_fail++;
            $display("FAIL dout_follow_hi: data_out=%b expected 1", data_out);
        end
        data_in = 7'b1111110;
        #1;
        n_checks++;
        if (data_out !== 1'b0) begin
            n_fail++;
            $display("FAIL dout_follow_lo: data_out=%b expected 0", data_out);
        end
        req = '0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || gnt !== 7'd0 || dbg_state !== SWITCH) begin
            n_fail++;
            $display("FAIL release_switch: busy=%b gnt=%b state=%0d expected 0/0/SWITCH",
                     busy, gnt, dbg_state);
        end
        @(negedge clk);
        data_in = '1;
        #1;
        n_checks++;
        if (dbg_state !== IDLE || sel !== 3'd0 || data_out !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_idle: state=%0d sel=%0d dout=%b expected IDLE/0/0",
                     dbg_state, sel, data_out);
        end
    endtask

    task automatic test_round_robin();
        int         cyc;
        int         hold;
        logic [2:0] e;
        logic [6:0] onehot;
        pulse_reset();
        req = '1;
        for (int k = 0; k < 8; k++) exp_q.push_back(3'(k % 7));
        for (int k = 0; k < 8; k++) begin
            e = 3'(k % 7);
            wait_grant(10, cyc);
            n_checks++;
            if (cyc != 1 || sel !== e) begin
                n_fail++;
                $display("FAIL rr_step%0d: sel=%0d after %0d cycles, expected sel=%0d after 1",
                         k, sel, cyc, e);
            end
            onehot  = 7'b0000001 << e;
            data_in = onehot;
            #1;
            n_checks++;
            if (data_out !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_dout%0d: data_out=%b expected 1", k, data_out);
            end
            data_in = ~onehot;
            hold = $urandom_range(0, 2);
            repeat (hold) @(negedge clk);
            req[e] = 1'b0;
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || gnt !== 7'd0 || sel !== e) begin
                n_fail++;
                $display("FAIL rr_switch%0d: busy=%b gnt=%b sel=%0d expected 0/0/%0d",
                         k, busy, gnt, sel, e);
            end
            if (k < 7) req = '1;
            else req = '0;
        end
        @(negedge clk);
    endtask

    task automatic test_sole_requester();
        int cyc;
        req = 7'b0100000;
        exp_q.push_back(3'd5);
        wait_grant(10, cyc);
        req = '0;
        exp_q.push_back(3'd5);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL sole_switch: busy=%b expected 0", busy);
        end
        req = 7'b0100000;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || sel !== 3'd5) begin
            n_fail++;
            $display("FAIL sole_regrant: busy=%b sel=%0d expected 1/5", busy, sel);
        end
        req = '0;
        data_in = '1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || sel !== 3'd5 || data_out !== 1'b0) begin
                n_fail++;
                $display("FAIL no_grant_hold%0d: busy=%b sel=%0d dout=%b expected 0/5/0",
                         i, busy, sel, data_out);
            end
        end
    endtask

    task automatic test_circular_order();
        int cyc;
        req = 7'b0000100;
        exp_q.push_back(3'd2);
        wait_grant(10, cyc);
        req = 7'b0001100;
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b1 || sel !== 3'd2) begin
                n_fail++;
                $display("FAIL other_req_ignored: busy=%b sel=%0d expected 1/2", busy, sel);
            end
        end
        req = 7'b0001000;
        exp_q.push_back(3'd3);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || dbg_state !== SWITCH) begin
            n_fail++;
            $display("FAIL circ_switch: busy=%b state=%0d expected 0/SWITCH", busy, dbg_state);
        end
        req = 7'b0001100;
        @(negedge clk);
        n_checks++;
        if (sel !== 3'd3) begin
            n_fail++;
            $display("FAIL holder_loses: sel=%0d expected 3", sel);
        end
        req = 7'b1000001;
        exp_q.push_back(3'd6);
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || sel !== 3'd6) begin
            n_fail++;
            $display("FAIL no_fixed_priority: busy=%b sel=%0d expected 1/6", busy, sel);
        end
        req = 7'b0000001;
        exp_q.push_back(3'd0);
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || sel !== 3'd0) begin
            n_fail++;
            $display("FAIL wrap_to_zero: busy=%b sel=%0d expected 1/0", busy, sel);
        end
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_grant();
        int cyc;
        req = 7'b0010000;
        exp_q.push_back(3'd4);
        wait_grant(10, cyc);
        n_checks++;
        if (sel !== 3'd4) begin
            n_fail++;
            $display("FAIL pre_reset_sel: sel=%0d expected 4", sel);
        end
        #3 resetn = 1'b0;
        #1;
        n_checks++;
        if (gnt !== 7'd0 || busy !== 1'b0 || sel !== 3'd0 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL async_reset: gnt=%b busy=%b sel=%0d state=%0d expected 0/0/0/IDLE",
                     gnt, busy, sel, dbg_state);
        end
        exp_q.push_back(3'd4);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || sel !== 3'd4) begin
            n_fail++;
            $display("FAIL post_reset_grant: busy=%b sel=%0d expected 1/4", busy, sel);
        end
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        int cyc;
        int run;
        pulse_reset();
        req = 7'b0001001;
`ifdef RR_ARB_TIMEOUT_EN
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd3);
        exp_q.push_back(3'd0);
        wait_grant(10, cyc);
        run = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy === 1'b1 && sel === 3'd0) run++;
            else break;
        end
        n_checks++;
        if (run != 4 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_first: held %0d cycles busy=%b, expected 4 then 0", run, busy);
        end
        wait_grant(10, cyc);
        run = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy === 1'b1 && sel === 3'd3) run++;
            else break;
        end
        n_checks++;
        if (cyc != 1 || run != 4 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_second: latency %0d held %0d busy=%b, expected 1/4/0",
                     cyc, run, busy);
        end
        wait_grant(10, cyc);
        req = '0;
`else
        exp_q.push_back(3'd0);
        wait_grant(10, cyc);
        run = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy === 1'b1 && sel === 3'd0) run++;
        end
        n_checks++;
        if (run != 21) begin
            n_fail++;
            $display("FAIL hold_forever: held %0d cycles, expected 21", run);
        end
        req = '0;
`endif
        repeat (3) @(negedge clk);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_reset_priority();
        test_round_robin();
        test_sole_requester();
        test_circular_order();
        test_reset_mid_grant();
        test_timeout();
        repeat (2) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d grants still expected, 0 required", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
